// File: rtl/controle_vagas_if.sv
// Sensor/tick inputs and occupancy outputs of the parking-lot controller.
// master drives sensors and tick; slave is the controller itself.
`timescale 1ns/1ps
interface controle_vagas_if #(
    parameter int CNT_W = 4
) ();
    logic             tick;
    logic             sensor_a;
    logic             sensor_b;
    logic [CNT_W-1:0] ocupacao;
    logic             cheio;
    logic             vazio;
    logic             entrada;
    logic             saida;
    logic             erro;

    modport master (
        output tick, sensor_a, sensor_b,
        input  ocupacao, cheio, vazio, entrada, saida, erro
    );

    modport slave (
        input  tick, sensor_a, sensor_b,
        output ocupacao, cheio, vazio, entrada, saida, erro
    );
endinterface

// File: rtl/controle_vagas.sv
// Parking-lot occupancy controller: entry/exit sequencing of two beam sensors on the
// divider tick. Define CONTROLE_VAGAS_DEBOUNCE_EN to add per-sensor tick debouncing.
`timescale 1ns/1ps
module controle_vagas #(
    parameter int CAPACIDADE    = 15,
    parameter int CNT_W         = 4,
    parameter int DEB_AMOSTRAS  = 4,
    parameter int TIMEOUT_TICKS = 800
) (
    input  logic              clk,
    input  logic              rst,
    controle_vagas_if.slave   bus
);
    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_E1   = 3'd1;
    localparam logic [2:0] ST_E2   = 3'd2;
    localparam logic [2:0] ST_E3   = 3'd3;
    localparam logic [2:0] ST_S1   = 3'd4;
    localparam logic [2:0] ST_S2   = 3'd5;
    localparam logic [2:0] ST_S3   = 3'd6;

    if ((2 ** CNT_W) <= CAPACIDADE || DEB_AMOSTRAS < 1 || TIMEOUT_TICKS < 2) begin : g_param_check
        $error("controle_vagas: invalid parameter set");
    end

    logic [1:0]       w_raw;
    logic [1:0]       w_s_next;
    logic [1:0]       r_s;
    logic [2:0]       r_state, w_state_next;
    logic [CNT_W-1:0] r_ocup, w_ocup_next;
    logic [TMO_W-1:0] r_tmo, w_tmo_next;
    logic             r_cheio, r_vazio, r_ent, r_sai, r_err;
    logic             w_ent, w_sai, w_err, w_change;

    // Bit 1 is the outer beam A, bit 0 the inner beam B.
    assign w_raw = {bus.sensor_a, bus.sensor_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sensor
            logic r_sync1, r_sync2;
`ifdef CONTROLE_VAGAS_DEBOUNCE_EN
            localparam int DEB_W = $clog2(DEB_AMOSTRAS + 1);
            logic [DEB_W-1:0] r_deb_cnt;
            logic             w_flip;

            assign w_flip       = bus.tick && (r_sync2 != r_s[gi]) &&
                                  (r_deb_cnt == DEB_W'(DEB_AMOSTRAS - 1));
            assign w_s_next[gi] = w_flip ? r_sync2 : r_s[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_deb_cnt <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    // Only an unbroken run of disagreeing samples may flip the output.
                    if (bus.tick) begin
                        if (r_sync2 == r_s[gi] || w_flip)
                            r_deb_cnt <= '0;
                        else
                            r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
            end
`else
            assign w_s_next[gi] = bus.tick ? r_sync2 : r_s[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end
`endif
        end
    endgenerate

    // The FSM looks at the freshly sampled pair so it reacts on the same tick edge.
    assign w_change = bus.tick && (w_s_next != r_s);

    always_comb begin
        w_state_next = r_state;
        w_ocup_next  = r_ocup;
        w_tmo_next   = r_tmo;
        w_ent        = 1'b0;
        w_sai        = 1'b0;
        w_err        = 1'b0;
        if (w_change) begin
            w_tmo_next = '0;
            case (r_state)
                ST_IDLE: begin
                    case (w_s_next)
                        2'b10:   w_state_next = ST_E1;
                        2'b01:   w_state_next = ST_S1;
                        2'b11:   w_err = 1'b1;
                        default: ;
                    endcase
                end
                ST_E1: begin
                    case (w_s_next)
                        2'b11:   w_state_next = ST_E2;
                        2'b00:   w_state_next = ST_IDLE;
                        default: begin w_err = 1'b1; w_state_next = ST_IDLE; end
                    endcase
                end
                ST_E2: begin
                    case (w_s_next)
                        2'b01:   w_state_next = ST_E3;
                        2'b10:   w_state_next = ST_E1;
                        default: begin w_err = 1'b1; w_state_next = ST_IDLE; end
                    endcase
                end
                ST_E3: begin
                    case (w_s_next)
                        2'b00: begin
                            w_state_next = ST_IDLE;
                            if (r_ocup < CNT_W'(CAPACIDADE)) begin
                                w_ocup_next = r_ocup + 1'b1;
                                w_ent       = 1'b1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        2'b11:   w_state_next = ST_E2;
                        default: begin w_err = 1'b1; w_state_next = ST_IDLE; end
                    endcase
                end
                ST_S1: begin
                    case (w_s_next)
                        2'b11:   w_state_next = ST_S2;
                        2'b00:   w_state_next = ST_IDLE;
                        default: begin w_err = 1'b1; w_state_next = ST_IDLE; end
                    endcase
                end
                ST_S2: begin
                    case (w_s_next)
                        2'b10:   w_state_next = ST_S3;
                        2'b01:   w_state_next = ST_S1;
                        default: begin w_err = 1'b1; w_state_next = ST_IDLE; end
                    endcase
                end
                ST_S3: begin
                    case (w_s_next)
                        2'b00: begin
                            w_state_next = ST_IDLE;
                            if (r_ocup != '0) begin
                                w_ocup_next = r_ocup - 1'b1;
                                w_sai       = 1'b1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        2'b11:   w_state_next = ST_S2;
                        default: begin w_err = 1'b1; w_state_next = ST_IDLE; end
                    endcase
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (bus.tick && r_state != ST_IDLE) begin
            if (r_tmo == TMO_W'(TIMEOUT_TICKS - 1)) begin
                w_err        = 1'b1;
                w_state_next = ST_IDLE;
            end else begin
                w_tmo_next = r_tmo + 1'b1;
            end
        end
        if (w_state_next == ST_IDLE)
            w_tmo_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= 2'b00;
            r_state <= ST_IDLE;
            r_ocup  <= '0;
            r_tmo   <= '0;
            r_cheio <= 1'b0;
            r_vazio <= 1'b1;
            r_ent   <= 1'b0;
            r_sai   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_s     <= w_s_next;
            r_state <= w_state_next;
            r_ocup  <= w_ocup_next;
            r_tmo   <= w_tmo_next;
            r_cheio <= (w_ocup_next == CNT_W'(CAPACIDADE));
            r_vazio <= (w_ocup_next == '0);
            r_ent   <= w_ent;
            r_sai   <= w_sai;
            r_err   <= w_err;
        end
    end

    assign bus.ocupacao = r_ocup;
    assign bus.cheio    = r_cheio;
    assign bus.vazio    = r_vazio;
    assign bus.entrada  = r_ent;
    assign bus.saida    = r_sai;
    assign bus.erro     = r_err;
endmodule

// File: tb/tb_controle_vagas.sv
// Bench for controle_vagas: directed and random sensor sequences checked every tick
// against a path-walking occupancy model.
`timescale 1ns/1ps
module tb_controle_vagas;
    localparam int CAP = 15;
    localparam int TMO = 800;
    localparam int DEB = 4;
`ifdef CONTROLE_VAGAS_DEBOUNCE_EN
    localparam int HT = DEB + 1;
`else
    localparam int HT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    controle_vagas_if #(.CNT_W(4)) bus ();

    controle_vagas #(
        .CAPACIDADE(CAP), .CNT_W(4), .DEB_AMOSTRAS(DEB), .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: a walk along the entry or exit path, indexed by position.
    logic [1:0] path_e [0:4];
    logic [1:0] path_s [0:4];
    logic [1:0] raw;
    logic [1:0] m_s;
    int m_ocup, m_dir, m_pos, m_tmo;
    int m_deb [0:1];
    bit e_ent, e_sai, e_err;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ocup = 0; m_dir = 0; m_pos = 0; m_tmo = 0; m_s = 2'b00;
        m_deb[0] = 0; m_deb[1] = 0;
    endtask

    task automatic model_tick();
        logic [1:0] s_new;
        logic [1:0] nxt, prv;
        e_ent = 0; e_sai = 0; e_err = 0;
        s_new = m_s;
`ifdef CONTROLE_VAGAS_DEBOUNCE_EN
        for (int i = 0; i < 2; i++) begin
            if (raw[i] != m_s[i]) begin
                m_deb[i]++;
                if (m_deb[i] == DEB) begin
                    s_new[i] = raw[i];
                    m_deb[i] = 0;
                end
            end else begin
                m_deb[i] = 0;
            end
        end
`else
        s_new = raw;
`endif
        if (s_new != m_s) begin
            m_s = s_new;
            m_tmo = 0;
            if (m_dir == 0) begin
                if (s_new == 2'b10) begin m_dir = 1; m_pos = 1; end
                else if (s_new == 2'b01) begin m_dir = 2; m_pos = 1; end
                else if (s_new == 2'b11) e_err = 1;
            end else begin
                nxt = (m_dir == 1) ? path_e[m_pos + 1] : path_s[m_pos + 1];
                prv = (m_dir == 1) ? path_e[m_pos - 1] : path_s[m_pos - 1];
                if (s_new == nxt) begin
                    m_pos++;
                    if (m_pos == 4) begin
                        if (m_dir == 1) begin
                            if (m_ocup < CAP) begin m_ocup++; e_ent = 1; end
                            else e_err = 1;
                        end else begin
                            if (m_ocup > 0) begin m_ocup--; e_sai = 1; end
                            else e_err = 1;
                        end
                        m_dir = 0; m_pos = 0;
                    end
                end else if (s_new == prv) begin
                    m_pos--;
                    if (m_pos == 0) m_dir = 0;
                end else begin
                    e_err = 1; m_dir = 0; m_pos = 0;
                end
            end
        end else if (m_dir != 0) begin
            m_tmo++;
            if (m_tmo == TMO) begin
                e_err = 1; m_dir = 0; m_pos = 0;
            end
        end
        if (m_dir == 0) m_tmo = 0;
    endtask

    task automatic tick_once();
        @(negedge clk) bus.tick = 1'b1;
        model_tick();
        @(negedge clk) bus.tick = 1'b0;
        chk("ocupacao", 8'(bus.ocupacao), 8'(m_ocup));
        chk("cheio",    8'(bus.cheio),    8'(m_ocup == CAP));
        chk("vazio",    8'(bus.vazio),    8'(m_ocup == 0));
        chk("entrada",  8'(bus.entrada),  8'(e_ent));
        chk("saida",    8'(bus.saida),    8'(e_sai));
        chk("erro",     8'(bus.erro),     8'(e_err));
        @(negedge clk);
        chk("pulse_low", 8'({bus.entrada, bus.saida, bus.erro}), 8'd0);
    endtask

    task automatic set_s(input logic a, input logic b);
        @(negedge clk);
        bus.sensor_a = a;
        bus.sensor_b = b;
        raw = {a, b};
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        set_s(a, b);
        repeat (n) tick_once();
    endtask

    task automatic walk_entry(input int n);
        hold(1, 0, n); hold(1, 1, n); hold(0, 1, n); hold(0, 0, n);
    endtask

    task automatic walk_exit(input int n);
        hold(0, 1, n); hold(1, 1, n); hold(1, 0, n); hold(0, 0, n);
    endtask

    initial begin
        int k;
        logic [1:0] rp;
        path_e = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        path_s = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        bus.tick = 1'b0; bus.sensor_a = 1'b0; bus.sensor_b = 1'b0; raw = 2'b00;
        model_reset();

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_ocupacao", 8'(bus.ocupacao), 8'd0);
        chk("rst_vazio",    8'(bus.vazio),    8'd1);
        chk("rst_cheio",    8'(bus.cheio),    8'd0);
        chk("rst_pulses",   8'({bus.entrada, bus.saida, bus.erro}), 8'd0);
        rst = 1'b0;

        // Single entry, every pair held 5 ticks
        hold(0, 0, 5);
        walk_entry(5);
        chk("entry_ocupacao", 8'(bus.ocupacao), 8'd1);
        chk("entry_vazio",    8'(bus.vazio),    8'd0);

        // Fill to capacity, then one entry too many, then one exit
        repeat (CAP - 1) walk_entry(HT);
        chk("full_cheio", 8'(bus.cheio), 8'd1);
        walk_entry(HT);
        chk("overfull_ocupacao", 8'(bus.ocupacao), 8'(CAP));
        walk_exit(HT);
        chk("exit_ocupacao", 8'(bus.ocupacao), 8'(CAP - 1));
        chk("exit_cheio",    8'(bus.cheio),    8'd0);

        // Back-out and illegal jump
        hold(1, 0, HT); hold(1, 1, HT); hold(1, 0, HT); hold(0, 0, HT);
        hold(1, 0, HT); hold(0, 1, HT); hold(0, 0, HT);

        // Timeout while half-way into an entry
        hold(1, 0, TMO + DEB + 2);
        hold(0, 0, HT);

        // Short glitch on A, then a real entry (glitch filtered only in debounce build)
        hold(1, 0, 3); hold(0, 0, HT);
        walk_entry(HT);

        // Randomized mix of walks and arbitrary sensor patterns
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 3);
            case (k)
                0: walk_entry($urandom_range(1, HT + 2));
                1: walk_exit($urandom_range(1, HT + 2));
                2: for (int j = 0; j < 4; j++) begin
                       rp = 2'($urandom_range(0, 3));
                       hold(rp[1], rp[0], $urandom_range(1, HT + 2));
                   end
                default: begin
                    hold(0, 1, HT); hold(1, 1, HT); hold(0, 1, HT); hold(0, 0, HT);
                end
            endcase
            hold(0, 0, HT);
        end

        // Reset colliding with the completing tick of an entry from ocupacao=3
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) walk_entry(HT);
        chk("pre_rst_ocupacao", 8'(bus.ocupacao), 8'd3);
        hold(1, 0, HT); hold(1, 1, HT); hold(0, 1, HT);
        set_s(0, 0);
`ifdef CONTROLE_VAGAS_DEBOUNCE_EN
        repeat (DEB - 1) tick_once();
`endif
        @(negedge clk) begin bus.tick = 1'b1; rst = 1'b1; end
        @(negedge clk) begin bus.tick = 1'b0; rst = 1'b0; end
        model_reset();
        chk("rst_tick_ocupacao", 8'(bus.ocupacao), 8'd0);
        chk("rst_tick_entrada",  8'(bus.entrada),  8'd0);
        chk("rst_tick_vazio",    8'(bus.vazio),    8'd1);
        hold(0, 0, HT);
        walk_entry(HT);
        chk("post_rst_ocupacao", 8'(bus.ocupacao), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/controle_vagas.md
# controle_vagas

Parking-lot occupancy controller. It samples two beam sensors (outer A, inner B) on the 400 Hz enable from the clock-conditioning counter and sequences them through an entry/exit state machine. It keeps a saturating occupancy count with full/empty flags and pulses per-event strobes for the display and barrier logic. It sits between the sensor pins and the display multiplexer, and its sampling rate is set by the divider tick.

## Interface
- CAPACIDADE, 15: number of spaces; the count saturates here.
- CNT_W, 4: width of `ocupacao`; must satisfy 2^CNT_W > CAPACIDADE.
- DEB_AMOSTRAS, 4: consecutive equal tick samples needed to accept a sensor change (debounce build only).
- TIMEOUT_TICKS, 800: ticks without a debounced sensor change before a non-IDLE sequence is aborted (2 s at 400 Hz).
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk enable pulse from the divider, nominally 400 Hz.
- sensor_a  in  1  outer beam, asynchronous, 1 = blocked.
- sensor_b  in  1  inner beam, asynchronous, 1 = blocked.
- ocupacao  out  CNT_W  current occupied spaces.
- cheio  out  1  ocupacao == CAPACIDADE.
- vazio  out  1  ocupacao == 0.
- entrada  out  1  one-clk pulse for a counted entry.
- saida  out  1  one-clk pulse for a counted exit.
- erro  out  1  one-clk pulse for an illegal transition, timeout, entry while full, or exit while empty.

## Operation
- Synchronizer: each sensor passes through 2 flops every clk. Only synchronized values are used.
- Debounced pair S = {a,b}. It is updated only on clk edges where tick=1.
- FSM states: IDLE, E1 (10), E2 (11), E3 (01), S1 (01), S2 (11), S3 (10). It evaluates only when tick=1.
- IDLE: S=10 → E1. S=01 → S1. S=00 stays. S=11 → erro, stay IDLE.
- Entry path: E1 goes to E2 on 11, then E3 on 01. E3 on 00 completes the entry and returns to IDLE.
- Exit path: S1 goes to S2 on 11, then S3 on 10. S3 on 00 completes the exit and returns to IDLE.
- Back-out moves one state backward and counts nothing: E2 on 10 → E1; E1 on 00 → IDLE; E3 on 11 → E2. Exit states mirror this.
- Any other S change from a non-IDLE state is illegal: pulse erro and go to IDLE.
- Entry completion:
  - If ocupacao < CAPACIDADE: increment it and pulse entrada.
  - Otherwise: count unchanged, pulse erro, no entrada.
- Exit completion:
  - If ocupacao > 0: decrement it and pulse saida.
  - Otherwise: count unchanged, pulse erro.
- Timeout counter:
  - Cleared on every S change and in IDLE.
  - Increments on each tick while in a non-IDLE state.
  - When it reaches TIMEOUT_TICKS: pulse erro, go to IDLE, count unchanged.
- cheio and vazio are registered and derived from the next ocupacao value, so they change on the same edge as ocupacao.

## Timing
- Reset values: state=IDLE, ocupacao=0, vazio=1, cheio=0, entrada=saida=erro=0. Synchronizer, debounce and timeout registers are all cleared.
- rst has priority over tick on the same edge. Reset during a sequence abandons it with no count change and no pulse.
- State, ocupacao, flags and pulses all update on the clk edge where tick=1 and the qualifying S is seen. Pulses are high for exactly one clk, then return low on the next edge.
- Sensor-to-S latency:
  - Non-debounce build: 2 clk of synchronization plus up to one tick period.
  - Debounce build: 2 clk plus DEB_AMOSTRAS ticks.
- tick held high for several clk behaves as several samples. The bench drives 1-clk ticks only.

## Configuration
- Macro: CONTROLE_VAGAS_DEBOUNCE_EN.
- Defined:
  - A per-sensor counter counts consecutive ticks where the synchronized value differs from the debounced value. Any tick where they agree clears the counter.
  - The debounced value flips when the counter reaches DEB_AMOSTRAS.
  - A and B are filtered independently.
- Undefined: S loads the synchronized pair on every tick. DEB_AMOSTRAS is ignored.

## Test plan
- Reset, then entry sequence 00→10→11→01→00, each held 5 ticks → entrada pulses once, ocupacao=1, vazio=0.
- Preload 15 entries, then a 16th entry → erro pulses, ocupacao stays 15, cheio=1, no entrada. Then one exit → saida pulses, ocupacao=14, cheio=0.
- Back-out: 10→11→10→00 → no pulses, ocupacao unchanged, state IDLE.
- Illegal jump: 10 then 01 → erro on that tick, state IDLE, count unchanged. Also hold 10 for 800 ticks → erro on tick 800.
- Debounce build with DEB_AMOSTRAS=4: a 3-tick glitch on sensor_a is ignored; a 4-tick assertion moves S to 10.
- Assert rst on the same edge as the completing tick of an entry from ocupacao=3 → ocupacao=0, no entrada.
